iob_rr_arbiter: RTL and testbench
=================================

Name: iob_rr_arbiter

Overview:
- Round-robin arbiter that shares one IOb-bus slave port among N_MASTERS IOb-bus masters.
- Typical use: the peripheral IOb bus ahead of the split, where the CPU path (after AXI-Lite to IOb conversion) and a second master (debug/DMA) both need the peripherals.
- Exactly one outstanding transaction at a time. A read keeps its grant until its response returns.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=2).
- ADDR_W, 32, IOb address width.
- DATA_W, 32, IOb data width; wstrb width is DATA_W/8.

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  reset; asynchronous, active-low.
- cke_i  in  1  clock enable; when 0, all registers hold.
- m_valid_i  in  N_MASTERS  per-master request valid.
- m_addr_i  in  N_MASTERS*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata_i  in  N_MASTERS*DATA_W  per-master write data.
- m_wstrb_i  in  N_MASTERS*DATA_W/8  per-master byte strobes; all zero means a read.
- m_ready_o  out  N_MASTERS  per-master request accepted.
- m_rvalid_o  out  N_MASTERS  per-master read data valid.
- m_rdata_o  out  DATA_W  read data, broadcast to all masters; qualified by m_rvalid_o.
- s_valid_o  out  1  slave request valid.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_wstrb_o  out  DATA_W/8  slave write strobes.
- s_ready_i  in  1  slave accepts the request.
- s_rvalid_i  in  1  slave read data valid.
- s_rdata_i  in  DATA_W  slave read data.
- grant_o  out  $clog2(N_MASTERS)  index of the master currently granted (debug).
- busy_o  out  1  high when state is not IDLE.

Behaviour:
- State machine: IDLE, ACCESS, RESP.
- Registers: state; grant index g; priority pointer ptr (last master served).

Reset (arst_n_i=0, asynchronous):
- state=IDLE, g=0, ptr=N_MASTERS-1, so master 0 has first priority.
- All outputs 0.
- Reset asserted mid-transaction abandons it immediately; s_valid_o drops asynchronously.

IDLE:
- All m_ready_o, m_rvalid_o and s_valid_o are 0.
- If any m_valid_i is 1: g <= first requester found scanning ptr+1, ptr+2, ... with modulo N_MASTERS wrap. Next state is ACCESS.
- Arbitration costs exactly 1 cycle. The earliest s_valid_o is the cycle after the master raises valid.

ACCESS:
- s_valid_o = m_valid_i[g].
- s_addr_o, s_wdata_o and s_wstrb_o are combinationally muxed from master g.
- m_ready_o[g] = s_ready_i; all other m_ready_o are 0.
- On s_ready_i=1 with a write (wstrb != 0): ptr <= g, go to IDLE.
- On s_ready_i=1 with a read and s_rvalid_i=0: go to RESP.
- On s_ready_i=1 with a read and s_rvalid_i=1 in the same cycle: m_rvalid_o[g]=1, ptr <= g, go to IDLE.
- If m_valid_i[g] drops before ready (protocol violation): go to IDLE with ptr unchanged and nothing forwarded.

RESP:
- s_valid_o=0.
- m_rvalid_o[g] = s_rvalid_i; all others 0.
- On s_rvalid_i=1: ptr <= g, go to IDLE.
- New requests are not accepted until the response returns.

Datapath and other rules:
- m_rdata_o = s_rdata_i at all times (unregistered).
- s_rvalid_i in IDLE, or in ACCESS during a write, is ignored and never forwarded.
- cke_i=0 freezes state, g and ptr. Combinational outputs still track their inputs.
- Fairness: a master that keeps valid asserted is served within N_MASTERS transactions.
- Throughput: one write every 2 cycles with a zero-wait slave. The IDLE cycle between transactions is mandatory.
- Slave-side outputs are undefined-but-stable outside ACCESS; s_addr_o, s_wdata_o and s_wstrb_o are driven 0 in IDLE and RESP.

Test Plan:
- Single write: m0 writes addr=0x100, wdata=0xDEADBEEF, wstrb=0xF; slave ready at once -> s_valid_o high in cycle 2 with those values, m_ready_o[0] high that cycle, busy_o low in cycle 3, m_ready_o[1] never high.
- Read with latency: m1 reads addr=0x20; slave ready in cycle 2, rvalid with rdata=0x12345678 in cycle 5 -> m_rvalid_o=2'b10 in cycle 5 only, m_rdata_o=0x12345678, grant_o=1 throughout.
- Contention: m0 and m1 each request continuously, 3 writes apiece, zero-wait slave -> service order 0,1,0,1,0,1 with one IDLE cycle between grants.
- Same-cycle ready and rvalid on a read -> m_rvalid_o[g] asserted that cycle, state returns to IDLE, no RESP cycle.
- Reset during RESP (arst_n_i low for 2 cycles) -> all outputs 0 immediately; a late s_rvalid_i after reset is ignored; the next request with both masters valid is granted to master 0.
- cke_i=0 for 4 cycles during ACCESS -> state and grant held; the transaction completes normally once cke_i=1 and s_ready_i=1.

Source files
------------

// File: rtl/iob_rr_arbiter_if.sv
// IOb bus bundle between N masters, the round-robin arbiter and one slave.
// The arbiter uses the slave modport; the environment (masters + peripheral) uses master.
interface iob_rr_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]          m_valid_i;
  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i;
  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i;
  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i;
  logic [N_MASTERS-1:0]          m_ready_o;
  logic [N_MASTERS-1:0]          m_rvalid_o;
  logic [DATA_W-1:0]             m_rdata_o;
  logic                          s_valid_o;
  logic [ADDR_W-1:0]             s_addr_o;
  logic [DATA_W-1:0]             s_wdata_o;
  logic [DATA_W/8-1:0]           s_wstrb_o;
  logic                          s_ready_i;
  logic                          s_rvalid_i;
  logic [DATA_W-1:0]             s_rdata_i;

  modport slave (
    input  m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_ready_i, s_rvalid_i, s_rdata_i,
    output m_ready_o, m_rvalid_o, m_rdata_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o
  );

  modport master (
    output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_ready_i, s_rvalid_i, s_rdata_i,
    input  m_ready_o, m_rvalid_o, m_rdata_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o
  );
endinterface

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave among N_MASTERS masters.
// One transaction in flight; a read holds its grant until the response returns.
module iob_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic                         cke_i,
  iob_rr_arbiter_if.slave              bus,
  output logic [$clog2(N_MASTERS)-1:0] grant_o,
  output logic                         busy_o
);
  localparam int GW     = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   ptr_q, ptr_d;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   cand;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  assign sel_addr  = bus.m_addr_i[int'(g_q)*ADDR_W +: ADDR_W];
  assign sel_wdata = bus.m_wdata_i[int'(g_q)*DATA_W +: DATA_W];
  assign sel_wstrb = bus.m_wstrb_i[int'(g_q)*STRB_W +: STRB_W];

  assign bus.m_rdata_o = bus.s_rdata_i;
  assign grant_o       = g_q;
  assign busy_o        = (state_q != IDLE);

  // First requester after the last-served master, wrapping modulo N_MASTERS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = GW'((int'(ptr_q) + k) % N_MASTERS);
      if (!pick_found && bus.m_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    g_d            = g_q;
    ptr_d          = ptr_q;
    bus.m_ready_o  = '0;
    bus.m_rvalid_o = '0;
    bus.s_valid_o  = 1'b0;
    bus.s_addr_o   = '0;
    bus.s_wdata_o  = '0;
    bus.s_wstrb_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          g_d     = pick_idx;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        bus.s_valid_o      = bus.m_valid_i[g_q];
        bus.s_addr_o       = sel_addr;
        bus.s_wdata_o      = sel_wdata;
        bus.s_wstrb_o      = sel_wstrb;
        bus.m_ready_o[g_q] = bus.s_ready_i;
        // A master withdrawing its request abandons the slot without moving priority.
        if (!bus.m_valid_i[g_q]) begin
          state_d = IDLE;
        end else if (bus.s_ready_i) begin
          if (sel_wstrb != '0) begin
            ptr_d   = g_q;
            state_d = IDLE;
          end else if (bus.s_rvalid_i) begin
            bus.m_rvalid_o[g_q] = 1'b1;
            ptr_d               = g_q;
            state_d             = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        bus.m_rvalid_o[g_q] = bus.s_rvalid_i;
        if (bus.s_rvalid_i) begin
          ptr_d   = g_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the last master so master 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= GW'(N_MASTERS - 1);
    end else if (cke_i) begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Bench for iob_rr_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model.
module tb_iob_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int GW = $clog2(N);

  logic          clk = 1'b0;
  logic          arst_n;
  logic          cke;
  logic [GW-1:0] grant;
  logic          busy;
  int            checks = 0;
  int            errors = 0;

  iob_rr_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  iob_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .cke_i   (cke),
    .bus     (bus),
    .grant_o (grant),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the slave, whether a read response is awaited,
  // and who was served last.
  bit mdl_active;
  bit mdl_wait;
  int mdl_grant;
  int mdl_last;

  task automatic model_reset();
    mdl_active = 0;
    mdl_wait   = 0;
    mdl_grant  = 0;
    mdl_last   = N - 1;
  endtask

  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [SW-1:0] strb_of(int i);
    return bus.m_wstrb_i[i*SW +: SW];
  endfunction

  task automatic model_step();
    if (!arst_n) begin
      model_reset();
    end else if (cke) begin
      if (!mdl_active) begin
        int p;
        p = rr_pick(mdl_last, bus.m_valid_i);
        if (p >= 0) begin
          mdl_grant  = p;
          mdl_active = 1;
          mdl_wait   = 0;
        end
      end else if (!mdl_wait) begin
        if (!bus.m_valid_i[mdl_grant]) mdl_active = 0;
        else if (bus.s_ready_i) begin
          if (strb_of(mdl_grant) != 0 || bus.s_rvalid_i) begin
            mdl_last   = mdl_grant;
            mdl_active = 0;
          end else begin
            mdl_wait = 1;
          end
        end
      end else if (bus.s_rvalid_i) begin
        mdl_last   = mdl_grant;
        mdl_active = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_valid_i  = '0;
    bus.m_addr_i   = '0;
    bus.m_wdata_i  = '0;
    bus.m_wstrb_i  = '0;
    bus.s_ready_i  = 1'b0;
    bus.s_rvalid_i = 1'b0;
    bus.s_rdata_i  = '0;
    cke            = 1'b1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    arst_n         = 1'b0;
    bus.m_valid_i  = '1;
    bus.m_wstrb_i  = '1;
    bus.s_ready_i  = 1'b1;
    bus.s_rvalid_i = 1'b1;
    #1;
    checks++; if (bus.s_valid_o !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b expected 0", bus.s_valid_o); end
    checks++; if (bus.m_ready_o !== '0) begin errors++; $display("FAIL reset_m_ready: got %b expected 00", bus.m_ready_o); end
    checks++; if (bus.m_rvalid_o !== '0) begin errors++; $display("FAIL reset_m_rvalid: got %b expected 00", bus.m_rvalid_o); end
    checks++; if (bus.s_addr_o !== '0 || bus.s_wstrb_o !== '0) begin errors++; $display("FAIL reset_s_bus: got addr %h strb %h expected 0", bus.s_addr_o, bus.s_wstrb_o); end
    checks++; if (busy !== 1'b0 || grant !== '0) begin errors++; $display("FAIL reset_busy_grant: got %b/%0d expected 0/0", busy, grant); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_held_busy: got %b expected 0", busy); end
    apply_reset();
  endtask

  task automatic test_single_write();
    bit saw_m1_ready = 0;
    apply_reset();
    bus.m_valid_i[0]        = 1'b1;
    bus.m_addr_i[0 +: AW]   = 32'h100;
    bus.m_wdata_i[0 +: DW]  = 32'hDEADBEEF;
    bus.m_wstrb_i[0 +: SW]  = 4'hF;
    bus.s_ready_i           = 1'b1;
    #1;
    saw_m1_ready |= bus.m_ready_o[1];
    checks++; if (bus.s_valid_o !== 1'b0) begin errors++; $display("FAIL wr_c1_s_valid: got %b expected 0", bus.s_valid_o); end
    tick();
    saw_m1_ready |= bus.m_ready_o[1];
    checks++; if (bus.s_valid_o !== 1'b1) begin errors++; $display("FAIL wr_c2_s_valid: got %b expected 1", bus.s_valid_o); end
    checks++; if (bus.s_addr_o !== 32'h100 || bus.s_wdata_o !== 32'hDEADBEEF || bus.s_wstrb_o !== 4'hF)
      begin errors++; $display("FAIL wr_c2_payload: got %h/%h/%h expected 100/deadbeef/f", bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o); end
    checks++; if (bus.m_ready_o !== 2'b01) begin errors++; $display("FAIL wr_c2_m_ready: got %b expected 01", bus.m_ready_o); end
    tick();
    bus.m_valid_i = '0;
    #1;
    saw_m1_ready |= bus.m_ready_o[1];
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_c3_busy: got %b expected 0", busy); end
    checks++; if (saw_m1_ready !== 1'b0) begin errors++; $display("FAIL wr_m1_ready: got %b expected 0", saw_m1_ready); end
    tick();
  endtask

  task automatic test_read_latency();
    apply_reset();
    bus.m_valid_i[1]       = 1'b1;
    bus.m_addr_i[AW +: AW] = 32'h20;
    bus.m_wstrb_i[SW +: SW] = '0;
    #1;
    tick();
    bus.s_ready_i = 1'b1;
    #1;
    checks++; if (bus.s_valid_o !== 1'b1 || bus.s_addr_o !== 32'h20) begin errors++; $display("FAIL rd_c2_req: got %b/%h expected 1/20", bus.s_valid_o, bus.s_addr_o); end
    checks++; if (bus.m_ready_o !== 2'b10) begin errors++; $display("FAIL rd_c2_m_ready: got %b expected 10", bus.m_ready_o); end
    tick();
    bus.m_valid_i = '0;
    bus.s_ready_i = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      bus.s_rvalid_i = (c == 5);
      bus.s_rdata_i  = (c == 5) ? 32'h12345678 : 32'h0;
      #1;
      checks++;
      if (bus.m_rvalid_o !== ((c == 5) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL rd_c%0d_m_rvalid: got %b expected %b", c, bus.m_rvalid_o, (c == 5) ? 2'b10 : 2'b00); end
      checks++;
      if (grant !== 1'b1) begin errors++; $display("FAIL rd_c%0d_grant: got %0d expected 1", c, grant); end
      if (c == 5) begin
        checks++; if (bus.m_rdata_o !== 32'h12345678) begin errors++; $display("FAIL rd_rdata: got %h expected 12345678", bus.m_rdata_o); end
        checks++; if (busy !== 1'b1 || bus.s_valid_o !== 1'b0) begin errors++; $display("FAIL rd_resp_state: got busy %b s_valid %b expected 1/0", busy, bus.s_valid_o); end
      end
      tick();
    end
    bus.s_rvalid_i = 1'b0;
  endtask

  task automatic test_contention();
    int served = 0;
    apply_reset();
    bus.m_valid_i = '1;
    bus.m_wstrb_i = '1;
    bus.m_addr_i  = {32'h200, 32'h100};
    bus.s_ready_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      #1;
      checks++;
      if (busy !== logic'(c % 2 == 0)) begin errors++; $display("FAIL cont_c%0d_busy: got %b expected %b", c, busy, c % 2 == 0); end
      if (bus.m_ready_o != '0) begin
        int idx = bus.m_ready_o[1] ? 1 : 0;
        checks++;
        if (idx != served % 2) begin errors++; $display("FAIL cont_order_%0d: got master %0d expected %0d", served, idx, served % 2); end
        served++;
      end
      tick();
    end
    checks++; if (served != 6) begin errors++; $display("FAIL cont_count: got %0d expected 6", served); end
    clear_inputs();
    tick();
  endtask

  task automatic test_same_cycle_read();
    apply_reset();
    bus.m_valid_i[0] = 1'b1;
    bus.m_wstrb_i    = '0;
    #1;
    tick();
    bus.s_ready_i  = 1'b1;
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i  = 32'hCAFE0001;
    #1;
    checks++; if (bus.m_rvalid_o !== 2'b01) begin errors++; $display("FAIL same_m_rvalid: got %b expected 01", bus.m_rvalid_o); end
    tick();
    bus.m_valid_i  = '0;
    bus.s_ready_i  = 1'b0;
    bus.s_rvalid_i = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_no_resp: got busy %b expected 0", busy); end
    tick();
  endtask

  task automatic test_reset_in_resp();
    apply_reset();
    // m0 write moves priority to m1, so only a reset returns it to m0.
    bus.m_valid_i[0] = 1'b1;
    bus.m_wstrb_i    = 8'h0F;
    bus.s_ready_i    = 1'b1;
    tick();
    tick();
    bus.m_valid_i = '0;
    #1;
    tick();
    bus.m_valid_i[0] = 1'b1;
    bus.m_wstrb_i    = '0;
    tick();
    tick();
    bus.m_valid_i = '0;
    bus.s_ready_i = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || bus.m_rvalid_o !== '0) begin errors++; $display("FAIL rresp_in_resp: got busy %b rvalid %b expected 1/00", busy, bus.m_rvalid_o); end
    bus.s_rvalid_i = 1'b1;
    arst_n         = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.m_rvalid_o !== '0 || bus.s_valid_o !== 1'b0 || grant !== '0)
      begin errors++; $display("FAIL rresp_async: got busy %b rvalid %b s_valid %b grant %0d expected 0", busy, bus.m_rvalid_o, bus.s_valid_o, grant); end
    tick();
    tick();
    arst_n = 1'b1;
    #1;
    checks++; if (bus.m_rvalid_o !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rresp_late_rvalid: got rvalid %b busy %b expected 00/0", bus.m_rvalid_o, busy); end
    tick();
    bus.s_rvalid_i = 1'b0;
    bus.m_valid_i  = '1;
    bus.m_wstrb_i  = '1;
    #1;
    tick();
    bus.s_ready_i = 1'b1;
    #1;
    checks++; if (grant !== '0 || bus.m_ready_o !== 2'b01) begin errors++; $display("FAIL rresp_regrant: got grant %0d ready %b expected 0/01", grant, bus.m_ready_o); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_cke_hold();
    apply_reset();
    bus.m_valid_i[1]        = 1'b1;
    bus.m_wstrb_i[SW +: SW] = 4'h3;
    cke = 1'b0;
    #1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cke_idle_hold: got busy %b expected 0", busy); end
    cke = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      cke           = 1'b0;
      bus.s_ready_i = (c >= 2);
      #1;
      checks++;
      if (busy !== 1'b1 || grant !== 1'b1 || bus.s_valid_o !== 1'b1) begin errors++; $display("FAIL cke_hold_%0d: got busy %b grant %0d s_valid %b expected 1/1/1", c, busy, grant, bus.s_valid_o); end
      tick();
    end
    cke           = 1'b1;
    bus.s_ready_i = 1'b1;
    #1;
    checks++; if (bus.m_ready_o !== 2'b10) begin errors++; $display("FAIL cke_complete: got %b expected 10", bus.m_ready_o); end
    tick();
    bus.m_valid_i = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cke_done_idle: got busy %b expected 0", busy); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  exp_ready, exp_rvalid, accepted;
    logic          exp_sv;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [SW-1:0] exp_st;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.m_valid_i[i] && $urandom_range(2) == 0) begin
          bus.m_valid_i[i]         = 1'b1;
          bus.m_addr_i[i*AW +: AW] = $urandom;
          bus.m_wdata_i[i*DW +: DW] = $urandom;
          bus.m_wstrb_i[i*SW +: SW] = ($urandom_range(1) == 1) ? SW'($urandom) : '0;
        end else if (bus.m_valid_i[i] && $urandom_range(60) == 0) begin
          bus.m_valid_i[i] = 1'b0;
        end
      end
      bus.s_ready_i  = 1'($urandom_range(1));
      bus.s_rvalid_i = ($urandom_range(2) == 0);
      bus.s_rdata_i  = $urandom;
      cke            = ($urandom_range(9) != 0);
      arst_n         = ($urandom_range(250) != 0);
      #1;
      if (!arst_n) model_reset();
      exp_ready = '0; exp_rvalid = '0; exp_sv = 1'b0;
      exp_addr  = '0; exp_wd = '0; exp_st = '0;
      if (mdl_active && !mdl_wait) begin
        exp_sv                = bus.m_valid_i[mdl_grant];
        exp_addr              = bus.m_addr_i[mdl_grant*AW +: AW];
        exp_wd                = bus.m_wdata_i[mdl_grant*DW +: DW];
        exp_st                = strb_of(mdl_grant);
        exp_ready[mdl_grant]  = bus.s_ready_i;
        exp_rvalid[mdl_grant] = bus.m_valid_i[mdl_grant] && bus.s_ready_i && exp_st == 0 && bus.s_rvalid_i;
      end else if (mdl_active) begin
        exp_rvalid[mdl_grant] = bus.s_rvalid_i;
      end
      checks++; if (bus.s_valid_o !== exp_sv) begin errors++; $display("FAIL rand_s_valid @%0d: got %b expected %b", c, bus.s_valid_o, exp_sv); end
      checks++; if ({bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o} !== {exp_addr, exp_wd, exp_st})
        begin errors++; $display("FAIL rand_s_payload @%0d: got %h/%h/%h expected %h/%h/%h", c, bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o, exp_addr, exp_wd, exp_st); end
      checks++; if (bus.m_ready_o !== exp_ready) begin errors++; $display("FAIL rand_m_ready @%0d: got %b expected %b", c, bus.m_ready_o, exp_ready); end
      checks++; if (bus.m_rvalid_o !== exp_rvalid) begin errors++; $display("FAIL rand_m_rvalid @%0d: got %b expected %b", c, bus.m_rvalid_o, exp_rvalid); end
      checks++; if (busy !== logic'(mdl_active) || int'(grant) != mdl_grant)
        begin errors++; $display("FAIL rand_state @%0d: got busy %b grant %0d expected %b/%0d", c, busy, grant, mdl_active, mdl_grant); end
      checks++; if (bus.m_rdata_o !== bus.s_rdata_i) begin errors++; $display("FAIL rand_rdata @%0d: got %h expected %h", c, bus.m_rdata_o, bus.s_rdata_i); end
      accepted = exp_ready & bus.m_valid_i & {N{cke & arst_n}};
      tick();
      bus.m_valid_i = bus.m_valid_i & ~accepted;
    end
    arst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  initial begin
    arst_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_read_latency();
    test_contention();
    test_same_cycle_read();
    test_reset_in_resp();
    test_cke_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
